pht_update_queue: RTL and testbench
===================================

// Module: pht_update_queue
// PURPOSE
//  Producer side of the PHT update port. Records one entry per predicted branch at fetch:
//   PHT index and predicted direction. Entries resolve in program order at execute.
//  On resolve, compares the actual direction with the stored prediction.
//  Drives the registered PHT update (valid/taken/index) and a misprediction flush pulse.
//  Sits between IF (push), EX (resolve) and the PHT update inputs.
// PARAMETERS
//  D_WIDTH    8   PHT index width; matches the PHT d_width
//  DEPTH      4   queue entries; power of 2, >= 2
//  CNT_WIDTH  16  width of the saturating misprediction counter
// PORTS
//  clk             in   1                 clock, rising edge
//  rst             in   1                 asynchronous, active-high reset
//  i_push          in   1                 IF: predicted branch enters pipeline
//  i_push_idx      in   D_WIDTH           PHT index used for the prediction
//  i_push_pred     in   1                 predicted direction (1 = taken)
//  i_resolve       in   1                 EX: oldest outstanding branch resolved
//  i_actual_taken  in   1                 resolved direction
//  i_flush         in   1                 external pipeline flush (jump/trap); clears queue
//  o_full          out  1                 count == DEPTH
//  o_empty         out  1                 count == 0
//  o_count         out  $clog2(DEPTH)+1   occupied entries
//  o_update        out  1                 PHT update strobe (-> PHT i_update)
//  o_actual_taken  out  1                 -> PHT i_actual_taken
//  o_addr_update   out  D_WIDTH           -> PHT i_addr_update
//  o_mispredict    out  1                 one-cycle pulse; IF redirect/flush request
//  o_error         out  1                 one-cycle pulse: push-when-full or resolve-when-empty
//  o_mispredict_cnt out CNT_WIDTH         saturating count of mispredictions
// BEHAVIOUR
//  - Reset (async, rst=1): pointers and count to 0. o_empty=1, o_full=0.
//    All pulses 0, o_addr_update=0, o_actual_taken=0, o_mispredict_cnt=0.
//    Reset mid-operation discards all entries immediately; no update issued for them.
//  - Storage: circular buffer. Write and read pointers are log2(DEPTH) bits, natural wrap.
//    count is tracked separately, so full and empty are unambiguous.
//  - Push: if i_push and not full (after a same-cycle pop), write {idx,pred} at wptr; wptr++.
//  - Resolve: if i_resolve and not empty, pop the head and compute mis = head.pred ^ i_actual_taken.
//    Next cycle, 1-cycle latency:
//      o_update=1, o_addr_update=head.idx, o_actual_taken=i_actual_taken, o_mispredict=mis.
//  - Resolve on empty: no pop, no update; o_error=1 next cycle.
//    A same-cycle push does not satisfy it (no bypass).
//  - Push when full with no same-cycle valid resolve: dropped, o_error=1 next cycle.
//    Full + push + resolve: both accepted, count unchanged.
//  - Mispredict (mis=1): at the same edge, every entry younger than the head is discarded
//    (wrong path). count=0, rptr=wptr. A same-cycle push is also dropped.
//    The update for the head is still issued.
//  - i_flush: clears the queue at the edge (count=0, rptr=wptr) and drops any same-cycle push.
//    A same-cycle valid resolve still pops the head and issues its update/mispredict first.
//  - Priority: rst > mispredict/i_flush clear > push/pop.
//  - o_mispredict_cnt: +1 per o_mispredict pulse; holds at 2^CNT_WIDTH-1.
//  - o_update, o_mispredict and o_error are single-cycle pulses, 0 otherwise.
//    o_addr_update and o_actual_taken hold their last value.
//  - o_full, o_empty and o_count are registered state, reflecting the post-edge queue.
// TESTING
//  1. Push (0x12,pred1); next cycle resolve taken=1
//     -> cycle after: o_update=1, addr=0x12, taken=1, o_mispredict=0; o_empty=1.
//  2. Push 0x01/0x02/0x03 (pred 0); resolve head taken=1
//     -> update addr=0x01, o_mispredict=1, o_count=0, o_mispredict_cnt=1; entries 0x02/0x03 never updated.
//  3. Fill DEPTH=4, push 5th -> o_error=1, count stays 4.
//     Then push+resolve in the same cycle -> count 4, new entry reaches head after 4 pops.
//  4. Resolve while empty, with a same-cycle push of 0x20 -> no o_update, o_error=1, o_count=1.
//  5. 3 entries; i_flush with resolve (head pred1, taken1) and push
//     -> update for the head only; o_count=0; push dropped.
//  6. Wrap: 10 push/resolve pairs in sequence -> updates in order; rst mid-stream -> o_count=0, no pulses.

Source files
------------

// File: rtl/pht_update_queue.sv
// Queue of outstanding branch predictions between fetch and execute.
// Resolves entries in program order and drives the registered PHT update port.
module pht_update_queue #(
   parameter int unsigned D_WIDTH   = 8,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [D_WIDTH-1:0]         i_push_idx,
   input  logic                       i_push_pred,
   input  logic                       i_resolve,
   input  logic                       i_actual_taken,
   input  logic                       i_flush,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_update,
   output logic                       o_actual_taken,
   output logic [D_WIDTH-1:0]         o_addr_update,
   output logic                       o_mispredict,
   output logic                       o_error,
   output logic [CNT_WIDTH-1:0]       o_mispredict_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [D_WIDTH-1:0]   idx_mem_q [DEPTH];
   logic [DEPTH-1:0]     pred_mem_q;

   logic [AW-1:0]        wptr_q, wptr_d;
   logic [AW-1:0]        rptr_q, rptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 full_q, empty_q;
   logic                 update_q, mis_q, err_q;
   logic                 taken_q, taken_d;
   logic [D_WIDTH-1:0]   addr_q, addr_d;
   logic [CNT_WIDTH-1:0] mcnt_q, mcnt_d;

   logic pop, mis, clear, push_ok, err, is_full, is_empty;

   // Pop/push acceptance and the wrong-path / flush clear
   always_comb begin
      is_full  = (count_q == CW'(DEPTH));
      is_empty = (count_q == '0);
      pop      = i_resolve && !is_empty;
      mis      = pop && (pred_mem_q[rptr_q] ^ i_actual_taken);
      clear    = mis || i_flush;
      push_ok  = i_push && (!is_full || pop) && !clear;
      err      = (i_resolve && is_empty) || (i_push && is_full && !pop);
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      addr_d  = addr_q;
      taken_d = taken_q;
      mcnt_d  = mcnt_q;
      if (clear) begin
         rptr_d  = wptr_q;
         count_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + AW'(1);
         if (pop)     rptr_d = rptr_q + AW'(1);
         count_d = count_q + CW'(push_ok) - CW'(pop);
      end
      if (pop) begin
         addr_d  = idx_mem_q[rptr_q];
         taken_d = i_actual_taken;
      end
      if (mis && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         update_q <= 1'b0;
         mis_q    <= 1'b0;
         err_q    <= 1'b0;
         taken_q  <= 1'b0;
         addr_q   <= '0;
         mcnt_q   <= '0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == CW'(DEPTH));
         empty_q  <= (count_d == '0);
         update_q <= pop;
         mis_q    <= mis;
         err_q    <= err;
         taken_q  <= taken_d;
         addr_q   <= addr_d;
         mcnt_q   <= mcnt_d;
      end
   end

   // Entry storage needs no reset: occupancy is tracked by the pointers and count
   always_ff @(posedge clk) begin
      if (push_ok) begin
         idx_mem_q[wptr_q]  <= i_push_idx;
         pred_mem_q[wptr_q] <= i_push_pred;
      end
   end

   assign o_full           = full_q;
   assign o_empty          = empty_q;
   assign o_count          = count_q;
   assign o_update         = update_q;
   assign o_actual_taken   = taken_q;
   assign o_addr_update    = addr_q;
   assign o_mispredict     = mis_q;
   assign o_error          = err_q;
   assign o_mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_pht_update_queue.sv
// Directed vector bench for pht_update_queue (DEPTH=4, D_WIDTH=8, CNT_WIDTH=16).
module tb_pht_update_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_push, i_push_pred, i_resolve, i_actual_taken, i_flush;
   logic [7:0]  i_push_idx;
   logic        o_full, o_empty, o_update, o_actual_taken, o_mispredict, o_error;
   logic [2:0]  o_count;
   logic [7:0]  o_addr_update;
   logic [15:0] o_mispredict_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pht_update_queue dut (
      .clk(clk), .rst(rst),
      .i_push(i_push), .i_push_idx(i_push_idx), .i_push_pred(i_push_pred),
      .i_resolve(i_resolve), .i_actual_taken(i_actual_taken), .i_flush(i_flush),
      .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
      .o_update(o_update), .o_actual_taken(o_actual_taken), .o_addr_update(o_addr_update),
      .o_mispredict(o_mispredict), .o_error(o_error), .o_mispredict_cnt(o_mispredict_cnt)
   );

   typedef struct {
      logic       push;
      logic [7:0] idx;
      logic       pred;
      logic       res;
      logic       tk;
      logic       fl;
      logic       e_upd;
      logic [7:0] e_addr;
      logic       e_tk;
      logic       e_mis;
      logic       e_err;
      logic [2:0] e_cnt;
      logic [15:0] e_mc;
   } vec_t;

   vec_t vecs [30];

   function automatic vec_t mk(logic push, logic [7:0] idx, logic pred, logic res, logic tk,
                               logic fl, logic e_upd, logic [7:0] e_addr, logic e_tk,
                               logic e_mis, logic e_err, logic [2:0] e_cnt, logic [15:0] e_mc);
      vec_t v;
      v.push = push; v.idx = idx; v.pred = pred; v.res = res; v.tk = tk; v.fl = fl;
      v.e_upd = e_upd; v.e_addr = e_addr; v.e_tk = e_tk; v.e_mis = e_mis;
      v.e_err = e_err; v.e_cnt = e_cnt; v.e_mc = e_mc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_state(input string tag, input logic upd, input logic [7:0] addr,
                            input logic tk, input logic mis, input logic err,
                            input logic [2:0] cnt, input logic [15:0] mc);
      n_vec++;
      chk({tag, ".update"},   32'(o_update), 32'(upd));
      chk({tag, ".addr"},     32'(o_addr_update), 32'(addr));
      chk({tag, ".taken"},    32'(o_actual_taken), 32'(tk));
      chk({tag, ".mispred"},  32'(o_mispredict), 32'(mis));
      chk({tag, ".error"},    32'(o_error), 32'(err));
      chk({tag, ".count"},    32'(o_count), 32'(cnt));
      chk({tag, ".full"},     32'(o_full), 32'(cnt == 3'd4));
      chk({tag, ".empty"},    32'(o_empty), 32'(cnt == 3'd0));
      chk({tag, ".mcnt"},     32'(o_mispredict_cnt), 32'(mc));
   endtask

   task automatic drive(input logic push, input logic [7:0] idx, input logic pred,
                        input logic res, input logic tk, input logic fl);
      @(negedge clk);
      i_push = push; i_push_idx = idx; i_push_pred = pred;
      i_resolve = res; i_actual_taken = tk; i_flush = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //           push idx   pr res tk fl | upd addr  tk mis err cnt mc
      vecs[0]  = mk(1, 8'h12, 1, 0, 0, 0,   0, 8'h00, 0, 0, 0, 1, 0);
      vecs[1]  = mk(0, 8'h00, 0, 1, 1, 0,   1, 8'h12, 1, 0, 0, 0, 0);
      vecs[2]  = mk(1, 8'h01, 0, 0, 0, 0,   0, 8'h12, 1, 0, 0, 1, 0);
      vecs[3]  = mk(1, 8'h02, 0, 0, 0, 0,   0, 8'h12, 1, 0, 0, 2, 0);
      vecs[4]  = mk(1, 8'h03, 0, 0, 0, 0,   0, 8'h12, 1, 0, 0, 3, 0);
      vecs[5]  = mk(0, 8'h00, 0, 1, 1, 0,   1, 8'h01, 1, 1, 0, 0, 1);
      vecs[6]  = mk(0, 8'h00, 0, 0, 0, 0,   0, 8'h01, 1, 0, 0, 0, 1);
      vecs[7]  = mk(0, 8'h00, 0, 1, 0, 0,   0, 8'h01, 1, 0, 1, 0, 1);
      vecs[8]  = mk(1, 8'h40, 1, 0, 0, 0,   0, 8'h01, 1, 0, 0, 1, 1);
      vecs[9]  = mk(1, 8'h41, 1, 0, 0, 0,   0, 8'h01, 1, 0, 0, 2, 1);
      vecs[10] = mk(1, 8'h42, 0, 0, 0, 0,   0, 8'h01, 1, 0, 0, 3, 1);
      vecs[11] = mk(1, 8'h43, 1, 0, 0, 0,   0, 8'h01, 1, 0, 0, 4, 1);
      vecs[12] = mk(1, 8'h44, 1, 0, 0, 0,   0, 8'h01, 1, 0, 1, 4, 1);
      vecs[13] = mk(1, 8'h45, 0, 1, 1, 0,   1, 8'h40, 1, 0, 0, 4, 1);
      vecs[14] = mk(0, 8'h00, 0, 1, 1, 0,   1, 8'h41, 1, 0, 0, 3, 1);
      vecs[15] = mk(0, 8'h00, 0, 1, 0, 0,   1, 8'h42, 0, 0, 0, 2, 1);
      vecs[16] = mk(0, 8'h00, 0, 1, 1, 0,   1, 8'h43, 1, 0, 0, 1, 1);
      vecs[17] = mk(0, 8'h00, 0, 1, 0, 0,   1, 8'h45, 0, 0, 0, 0, 1);
      vecs[18] = mk(1, 8'h20, 1, 1, 1, 0,   0, 8'h45, 0, 0, 1, 1, 1);
      vecs[19] = mk(0, 8'h00, 0, 1, 1, 0,   1, 8'h20, 1, 0, 0, 0, 1);
      vecs[20] = mk(1, 8'h50, 1, 0, 0, 0,   0, 8'h20, 1, 0, 0, 1, 1);
      vecs[21] = mk(1, 8'h51, 0, 0, 0, 0,   0, 8'h20, 1, 0, 0, 2, 1);
      vecs[22] = mk(1, 8'h52, 0, 0, 0, 0,   0, 8'h20, 1, 0, 0, 3, 1);
      vecs[23] = mk(1, 8'h53, 1, 1, 1, 1,   1, 8'h50, 1, 0, 0, 0, 1);
      vecs[24] = mk(0, 8'h00, 0, 1, 0, 0,   0, 8'h50, 1, 0, 1, 0, 1);
      vecs[25] = mk(1, 8'h60, 0, 0, 0, 0,   0, 8'h50, 1, 0, 0, 1, 1);
      vecs[26] = mk(1, 8'h61, 1, 1, 1, 0,   1, 8'h60, 1, 1, 0, 0, 2);
      vecs[27] = mk(0, 8'h00, 0, 0, 0, 0,   0, 8'h60, 1, 0, 0, 0, 2);
      vecs[28] = mk(1, 8'h70, 1, 0, 0, 0,   0, 8'h60, 1, 0, 0, 1, 2);
      vecs[29] = mk(0, 8'h00, 0, 0, 0, 1,   0, 8'h60, 1, 0, 0, 0, 2);

      rst = 1'b1;
      i_push = 0; i_push_idx = '0; i_push_pred = 0;
      i_resolve = 0; i_actual_taken = 0; i_flush = 0;
      #12;
      chk_state("reset", 0, 8'h00, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 30; i++) begin
         drive(vecs[i].push, vecs[i].idx, vecs[i].pred, vecs[i].res, vecs[i].tk, vecs[i].fl);
         chk_state($sformatf("vec%0d", i), vecs[i].e_upd, vecs[i].e_addr, vecs[i].e_tk,
                   vecs[i].e_mis, vecs[i].e_err, vecs[i].e_cnt, vecs[i].e_mc);
      end

      // Overlapped push/resolve stream wraps both pointers several times
      for (int k = 0; k < 10; k++) begin
         logic pk, pprev;
         pk    = k[0];
         pprev = ~k[0];
         drive(1, 8'(8'h80 + k), pk, k > 0, pprev, 0);
         if (k == 0) chk_state("wrap0", 0, 8'h60, 1, 0, 0, 1, 2);
         else chk_state($sformatf("wrap%0d", k), 1, 8'(8'h80 + k - 1), pprev, 0, 0, 1, 2);
      end
      drive(0, 8'h00, 0, 1, 1, 0);
      chk_state("wrap_last", 1, 8'h89, 1, 0, 0, 0, 2);

      // Asynchronous reset while an update pulse is live and entries are queued
      drive(1, 8'hA0, 1, 0, 0, 0);
      drive(1, 8'hA1, 0, 0, 0, 0);
      drive(1, 8'hA2, 0, 1, 1, 0);
      chk_state("pre_rst", 1, 8'hA0, 1, 0, 0, 2, 2);
      #1 rst = 1'b1;
      #1;
      chk_state("async_rst", 0, 8'h00, 0, 0, 0, 0, 0);
      drive(0, 8'h00, 0, 1, 1, 0);
      chk_state("rst_held", 0, 8'h00, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 8'h00, 0, 1, 0, 0);
      chk_state("post_rst", 0, 8'h00, 0, 0, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
